fan_tach_meter: RTL

//   Measures fan speed from the tachometer pin ahead of the fan speed control loop.
//   - Synchronises and glitch-filters tach_i.
//   - Counts rising edges over a fixed window of wb_clk_i cycles.
//   - Publishes the count with a one-cycle valid strobe; the downstream controller consumes it.

---
 rtl/fan_tach_meter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fan_tach_meter.sv
// Fan tachometer speed meter: synchronise and glitch-filter tach_i, count rising edges per window.
// Optional stall detector is built only when the TACH_STALL_EN macro is defined.
module fan_tach_meter #(
  parameter int unsigned WINDOW_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned FILT_LEN      = 4,
  parameter int unsigned STALL_WINDOWS = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             tach_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] speed_o,
  output logic             speed_valid_o,
  output logic             ovf_o,
  output logic             stall_o
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
  localparam int unsigned RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } mode_e;

  mode_e             mode;
  logic [1:0]        sync_q;
  logic              tach_sync;
  logic              filt_q;
  logic [RUN_W-1:0]  run_cnt;
  logic              filt_flip;
  logic              edge_now;
  logic [WIN_W-1:0]  win_cnt;
  logic              terminal;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sat_q;
  logic [CNT_W-1:0]  cnt_next;
  logic              over_now;

  // Mode follows enable_i directly; there is no registered state machine.
  always_comb begin
    mode = enable_i ? MEASURE : IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], tach_i};
    end
  end

  assign tach_sync = sync_q[1];

  // The level flips on the FILT_LEN-th consecutive disagreeing sample; that same cycle is the edge.
  assign filt_flip = (tach_sync != filt_q) && (run_cnt == RUN_LAST);
  assign edge_now  = filt_flip && !filt_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      filt_q  <= 1'b0;
      run_cnt <= '0;
    end else if (tach_sync == filt_q) begin
      run_cnt <= '0;
    end else if (filt_flip) begin
      filt_q  <= ~filt_q;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + RUN_W'(1);
    end
  end

  assign terminal = (mode == MEASURE) && (win_cnt == WIN_LAST);

  // sat_q remembers an edge lost to saturation earlier in the window, so ovf reflects the true total.
  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    cnt_next = edge_cnt;
    over_now = sat_q;
    if (edge_now) begin
      if (edge_cnt == CNT_MAX) begin
        over_now = 1'b1;
      end else begin
        cnt_next = edge_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      win_cnt       <= '0;
      edge_cnt      <= '0;
      sat_q         <= 1'b0;
      speed_o       <= '0;
      ovf_o         <= 1'b0;
      speed_valid_o <= 1'b0;
    end else if (mode == IDLE) begin
      win_cnt       <= '0;
      edge_cnt      <= '0;
      sat_q         <= 1'b0;
      speed_valid_o <= 1'b0;
    end else begin
      speed_valid_o <= terminal;
      if (terminal) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
        sat_q    <= 1'b0;
        speed_o  <= cnt_next;
        ovf_o    <= over_now;
      end else begin
        win_cnt  <= win_cnt + WIN_W'(1);
        edge_cnt <= cnt_next;
        sat_q    <= over_now;
      end
    end
  end

`ifdef TACH_STALL_EN
  localparam int unsigned ST_W = $clog2(STALL_WINDOWS + 1);
  localparam logic [ST_W-1:0] ST_LIM  = ST_W'(STALL_WINDOWS);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STALL_WINDOWS - 1);

  logic [ST_W-1:0] stall_cnt;

  // A closing window with nothing counted (and no overflow) extends the zero run.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stall_cnt <= '0;
      stall_o   <= 1'b0;
    end else if (terminal) begin
      if ((cnt_next == '0) && !over_now) begin
        if (stall_cnt != ST_LIM) begin
          stall_cnt <= stall_cnt + ST_W'(1);
        end
        if (stall_cnt >= ST_LAST) begin
          stall_o <= 1'b1;
        end
      end else begin
        stall_cnt <= '0;
        stall_o   <= 1'b0;
      end
    end
  end
`else
  assign stall_o = 1'b0;
`endif

endmodule
